// File: rtl/scr1_memory_wb_pkg.sv
// Shared definitions for the scr1_memory_wb simulation memory model:
// bus width, MMIO register addresses and the per-port address decode.
package scr1_memory_wb_pkg;

  localparam int SCR1_WB_WIDTH = 32;

  localparam logic [SCR1_WB_WIDTH-1:0] MMIO_PRINT    = 32'hF000_0000;
  localparam logic [SCR1_WB_WIDTH-1:0] MMIO_EXT_IRQ  = 32'hF000_0100;
  localparam logic [SCR1_WB_WIDTH-1:0] MMIO_SOFT_IRQ = 32'hF000_0200;

  // One-hot (or all-zero) decode of a word-aligned address.
  // All-zero means the address is unmapped for that port.
  typedef struct packed {
    logic mem;
    logic print;
    logic ext_irq;
    logic soft_irq;
  } dec_t;

endpackage

// File: rtl/scr1_memory_wb_port.sv
// Wishbone slave handshake engine for one port of scr1_memory_wb.
//   clk, rst  : clock, async active-high reset
//   stall_in  : ack-stall pattern, loaded into sp while rst is high
//   stb, adr  : request strobe and byte address from the master
//   go        : a legal access executes at the coming edge (combinational)
//   dec       : address decode of the current request
//   ack, err  : registered one-cycle response pulses
module scr1_memory_wb_port
  import scr1_memory_wb_pkg::*;
#(
  parameter int MEM_POWER = 20,
  parameter bit MMIO_EN   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SCR1_WB_WIDTH-1:0] stall_in,
  input  logic                     stb,
  input  logic [SCR1_WB_WIDTH-1:0] adr,
  output logic                     go,
  output dec_t                     dec,
  output logic                     ack,
  output logic                     err
);

  logic [SCR1_WB_WIDTH-1:0] sp;
  logic [SCR1_WB_WIDTH-1:0] eff;
  logic                     pending;
  logic                     exec;
  logic                     valid;

  assign eff = {adr[SCR1_WB_WIDTH-1:2], 2'b00};

  always_comb begin
    dec          = '0;
    dec.mem      = (eff >> MEM_POWER) == '0;
    dec.print    = MMIO_EN && (eff == MMIO_PRINT);
    dec.ext_irq  = MMIO_EN && (eff == MMIO_EXT_IRQ);
    dec.soft_irq = MMIO_EN && (eff == MMIO_SOFT_IRQ);
  end

  assign valid   = |dec;
  // A request is not pending in the cycle its response is visible,
  // which forces the one idle cycle between transfers.
  assign pending = stb & ~ack & ~err;
  assign exec    = pending & ~sp[0];
  assign go      = exec & valid;

  // The stall pattern is reloaded continuously while reset is held so the
  // bench can change it between phases by pulsing reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp  <= stall_in;
      ack <= 1'b0;
      err <= 1'b0;
    end else begin
      ack <= go;
      err <= exec & ~valid;
      if (pending) sp <= {sp[0], sp[SCR1_WB_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/scr1_memory_wb.sv
// Dual-port Wishbone simulation memory for the SCR1 core (bench side).
//   clk, rst                : clock, async active-high reset
//   ext_irq, soft_irq       : interrupt lines driven from dmem MMIO writes
//   *_req_ack_stall_in      : per-port ack-stall patterns (sampled in reset)
//   wbd_imem_* / wbd_dmem_* : Wishbone slave ports (stb/adr/we/dat/sel in,
//                             dat/ack/err out)
// The byte array `memory` is shared and is never cleared by reset.
// MMIO (console, irq registers) is reachable from the dmem port only.
module scr1_memory_wb
  import scr1_memory_wb_pkg::*;
#(
  parameter int SCR1_MEM_POWER_SIZE = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ext_irq,
  output logic                     soft_irq,
  input  logic [SCR1_WB_WIDTH-1:0] imem_req_ack_stall_in,
  input  logic [SCR1_WB_WIDTH-1:0] dmem_req_ack_stall_in,
  input  logic                     wbd_imem_stb_i,
  input  logic [SCR1_WB_WIDTH-1:0] wbd_imem_adr_i,
  input  logic                     wbd_imem_we_i,
  input  logic [SCR1_WB_WIDTH-1:0] wbd_imem_dat_i,
  input  logic [3:0]               wbd_imem_sel_i,
  output logic [SCR1_WB_WIDTH-1:0] wbd_imem_dat_o,
  output logic                     wbd_imem_ack_o,
  output logic                     wbd_imem_err_o,
  input  logic                     wbd_dmem_stb_i,
  input  logic [SCR1_WB_WIDTH-1:0] wbd_dmem_adr_i,
  input  logic                     wbd_dmem_we_i,
  input  logic [SCR1_WB_WIDTH-1:0] wbd_dmem_dat_i,
  input  logic [3:0]               wbd_dmem_sel_i,
  output logic [SCR1_WB_WIDTH-1:0] wbd_dmem_dat_o,
  output logic                     wbd_dmem_ack_o,
  output logic                     wbd_dmem_err_o
);

  localparam int P = SCR1_MEM_POWER_SIZE;

  logic [7:0] memory [0:(2**P)-1];

  logic                     i_go, d_go;
  dec_t                     i_dec, d_dec;
  logic [P-1:0]             i_idx, d_idx;
  logic [SCR1_WB_WIDTH-1:0] i_word, d_word, d_rdata;
  logic                     unused_ok;

  scr1_memory_wb_port #(.MEM_POWER(P), .MMIO_EN(1'b0)) u_imem (
    .clk(clk), .rst(rst), .stall_in(imem_req_ack_stall_in),
    .stb(wbd_imem_stb_i), .adr(wbd_imem_adr_i),
    .go(i_go), .dec(i_dec), .ack(wbd_imem_ack_o), .err(wbd_imem_err_o)
  );

  scr1_memory_wb_port #(.MEM_POWER(P), .MMIO_EN(1'b1)) u_dmem (
    .clk(clk), .rst(rst), .stall_in(dmem_req_ack_stall_in),
    .stb(wbd_dmem_stb_i), .adr(wbd_dmem_adr_i),
    .go(d_go), .dec(d_dec), .ack(wbd_dmem_ack_o), .err(wbd_dmem_err_o)
  );

  assign i_idx = {wbd_imem_adr_i[P-1:2], 2'b00};
  assign d_idx = {wbd_dmem_adr_i[P-1:2], 2'b00};

  assign i_word = {memory[i_idx + P'(3)], memory[i_idx + P'(2)],
                   memory[i_idx + P'(1)], memory[i_idx]};
  assign d_word = {memory[d_idx + P'(3)], memory[d_idx + P'(2)],
                   memory[d_idx + P'(1)], memory[d_idx]};

  always_comb begin
    d_rdata = '0;
    if (d_dec.mem)           d_rdata = d_word;
    else if (d_dec.ext_irq)  d_rdata = {31'b0, ext_irq};
    else if (d_dec.soft_irq) d_rdata = {31'b0, soft_irq};
  end

  // dmem is applied after imem so that it wins a same-edge byte collision.
  always_ff @(posedge clk) begin
    if (i_go && wbd_imem_we_i && i_dec.mem)
      for (int b = 0; b < 4; b++)
        if (wbd_imem_sel_i[b]) memory[i_idx + P'(b)] <= wbd_imem_dat_i[8*b +: 8];
    if (d_go && wbd_dmem_we_i && d_dec.mem)
      for (int b = 0; b < 4; b++)
        if (wbd_dmem_sel_i[b]) memory[d_idx + P'(b)] <= wbd_dmem_dat_i[8*b +: 8];
  end

  // dat_o is non-zero only in the ack cycle of a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbd_imem_dat_o <= '0;
      wbd_dmem_dat_o <= '0;
      ext_irq        <= 1'b0;
      soft_irq       <= 1'b0;
    end else begin
      wbd_imem_dat_o <= (i_go && !wbd_imem_we_i) ? i_word : '0;
      wbd_dmem_dat_o <= (d_go && !wbd_dmem_we_i) ? d_rdata : '0;
      if (d_go && wbd_dmem_we_i && d_dec.ext_irq)  ext_irq  <= wbd_dmem_dat_i[0];
      if (d_go && wbd_dmem_we_i && d_dec.soft_irq) soft_irq <= wbd_dmem_dat_i[0];
    end
  end

  // Console output: simulation-only side effect of the print register.
  always_ff @(posedge clk) begin
    if (!rst && d_go && wbd_dmem_we_i && d_dec.print)
      $write("%c", wbd_dmem_dat_i[7:0]);
  end

  assign unused_ok = ^{wbd_imem_adr_i[1:0], wbd_dmem_adr_i[1:0],
                       wbd_imem_adr_i[SCR1_WB_WIDTH-1:P], wbd_dmem_adr_i[SCR1_WB_WIDTH-1:P],
                       i_dec.print, i_dec.ext_irq, i_dec.soft_irq};

endmodule

// File: tb/tb_scr1_memory_wb.sv
// Self-checking bench for scr1_memory_wb: per-port expected-response
// queues are filled when a request is driven and drained on ack/err.
module tb_scr1_memory_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_irq, soft_irq;
  logic [31:0] imem_req_ack_stall_in, dmem_req_ack_stall_in;
  logic        wbd_imem_stb_i, wbd_imem_we_i, wbd_imem_ack_o, wbd_imem_err_o;
  logic [31:0] wbd_imem_adr_i, wbd_imem_dat_i, wbd_imem_dat_o;
  logic [3:0]  wbd_imem_sel_i;
  logic        wbd_dmem_stb_i, wbd_dmem_we_i, wbd_dmem_ack_o, wbd_dmem_err_o;
  logic [31:0] wbd_dmem_adr_i, wbd_dmem_dat_i, wbd_dmem_dat_o;
  logic [3:0]  wbd_dmem_sel_i;

  scr1_memory_wb dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .soft_irq(soft_irq),
    .imem_req_ack_stall_in(imem_req_ack_stall_in),
    .dmem_req_ack_stall_in(dmem_req_ack_stall_in),
    .wbd_imem_stb_i(wbd_imem_stb_i), .wbd_imem_adr_i(wbd_imem_adr_i),
    .wbd_imem_we_i(wbd_imem_we_i), .wbd_imem_dat_i(wbd_imem_dat_i),
    .wbd_imem_sel_i(wbd_imem_sel_i), .wbd_imem_dat_o(wbd_imem_dat_o),
    .wbd_imem_ack_o(wbd_imem_ack_o), .wbd_imem_err_o(wbd_imem_err_o),
    .wbd_dmem_stb_i(wbd_dmem_stb_i), .wbd_dmem_adr_i(wbd_dmem_adr_i),
    .wbd_dmem_we_i(wbd_dmem_we_i), .wbd_dmem_dat_i(wbd_dmem_dat_i),
    .wbd_dmem_sel_i(wbd_dmem_sel_i), .wbd_dmem_dat_o(wbd_dmem_dat_o),
    .wbd_dmem_ack_o(wbd_dmem_ack_o), .wbd_dmem_err_o(wbd_dmem_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t       q_i[$];
  exp_t       q_d[$];
  logic [7:0] ref_mem [logic [31:0]];
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [31:0] e;
    e = {a[31:2], 2'b00};
    return {ref_mem[e+3], ref_mem[e+2], ref_mem[e+1], ref_mem[e]};
  endfunction

  function automatic void ref_wr(input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] sel);
    logic [31:0] e;
    e = {a[31:2], 2'b00};
    for (int b = 0; b < 4; b++)
      if (sel[b]) ref_mem[e + 32'(b)] = d[8*b +: 8];
  endfunction

  task automatic do_reset(input logic [31:0] istall, input logic [31:0] dstall);
    rst = 1'b1;
    imem_req_ack_stall_in = istall;
    dmem_req_ack_stall_in = dstall;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete transfer on one port; latency counts edges after stb rises.
  task automatic xfer(input bit imem, input bit we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input logic exp_err, input logic [31:0] exp_dat,
                      input int exp_lat, input string nm);
    exp_t        e, g;
    int          lat;
    logic        a, er;
    logic [31:0] d;
    @(negedge clk);
    if (imem) begin
      wbd_imem_adr_i = adr; wbd_imem_we_i = we; wbd_imem_dat_i = dat;
      wbd_imem_sel_i = sel; wbd_imem_stb_i = 1'b1;
    end else begin
      wbd_dmem_adr_i = adr; wbd_dmem_we_i = we; wbd_dmem_dat_i = dat;
      wbd_dmem_sel_i = sel; wbd_dmem_stb_i = 1'b1;
    end
    e = '{exp_err, exp_dat, exp_lat};
    if (imem) q_i.push_back(e); else q_d.push_back(e);
    lat = 0; a = 1'b0; er = 1'b0; d = '0;
    while (lat < 64 && !a && !er) begin
      @(posedge clk); #1;
      lat++;
      a  = imem ? wbd_imem_ack_o : wbd_dmem_ack_o;
      er = imem ? wbd_imem_err_o : wbd_dmem_err_o;
      d  = imem ? wbd_imem_dat_o : wbd_dmem_dat_o;
    end
    g = imem ? q_i.pop_front() : q_d.pop_front();
    if (imem) wbd_imem_stb_i = 1'b0; else wbd_dmem_stb_i = 1'b0;
    n_cmp++;
    if (!a && !er) begin
      n_err++;
      $display("FAIL %s timeout: no ack/err after %0d edges", nm, lat);
    end else begin
      if ({a, er} !== {~g.is_err, g.is_err}) begin
        n_err++;
        $display("FAIL %s resp: ack=%0b err=%0b, required err=%0b", nm, a, er, g.is_err);
      end
      n_cmp++;
      if (d !== g.data) begin
        n_err++;
        $display("FAIL %s data: got %h required %h", nm, d, g.data);
      end
      n_cmp++;
      if (lat != g.lat) begin
        n_err++;
        $display("FAIL %s latency: got %0d required %0d", nm, lat, g.lat);
      end
    end
    @(posedge clk); #1;
    a  = imem ? wbd_imem_ack_o : wbd_dmem_ack_o;
    er = imem ? wbd_imem_err_o : wbd_dmem_err_o;
    n_cmp++;
    if ({a, er} !== 2'b00) begin
      n_err++;
      $display("FAIL %s pulse: ack=%0b err=%0b one cycle later, required 0", nm, a, er);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({wbd_imem_ack_o, wbd_imem_err_o, wbd_dmem_ack_o, wbd_dmem_err_o} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_ackerr: got %b required 0000",
               {wbd_imem_ack_o, wbd_imem_err_o, wbd_dmem_ack_o, wbd_dmem_err_o});
    end
    n_cmp++;
    if (wbd_imem_dat_o !== 32'h0) begin
      n_err++; $display("FAIL reset_imem_dat: got %h required 0", wbd_imem_dat_o);
    end
    n_cmp++;
    if (wbd_dmem_dat_o !== 32'h0) begin
      n_err++; $display("FAIL reset_dmem_dat: got %h required 0", wbd_dmem_dat_o);
    end
    n_cmp++;
    if ({ext_irq, soft_irq} !== 2'b00) begin
      n_err++; $display("FAIL reset_irq: got %b required 00", {ext_irq, soft_irq});
    end
    rst = 1'b0;
  endtask

  task automatic test_rw();
    ref_wr(32'h100, 32'h1122_3344, 4'hF);
    xfer(0, 1, 32'h100, 32'h1122_3344, 4'hF, 0, 32'h0, 1, "wr_full");
    xfer(0, 0, 32'h100, 32'h0, 4'hF, 0, ref_rd(32'h100), 1, "rd_full");
    ref_wr(32'h100, 32'hAABB_CCDD, 4'b0101);
    xfer(0, 1, 32'h100, 32'hAABB_CCDD, 4'b0101, 0, 32'h0, 1, "wr_sel0101");
    xfer(0, 0, 32'h100, 32'h0, 4'h0, 0, 32'h11BB_33DD, 1, "rd_sel0101");
    xfer(0, 0, 32'h103, 32'h0, 4'h1, 0, ref_rd(32'h100), 1, "rd_unaligned");
    // top word of the array vs first address past it
    ref_wr(32'h000F_FFFC, 32'hCAFE_F00D, 4'hF);
    xfer(0, 1, 32'h000F_FFFC, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 1, "wr_top");
    xfer(1, 0, 32'h000F_FFFC, 32'h0, 4'hF, 0, ref_rd(32'h000F_FFFC), 1, "rd_top_imem");
    xfer(0, 0, 32'h0010_0000, 32'h0, 4'hF, 1, 32'h0, 1, "rd_past_end");
  endtask

  task automatic test_imem_stall();
    do_reset(32'h0000_0003, 32'h0);
    xfer(1, 0, 32'h0, 32'h0, 4'hF, 0, ref_rd(32'h0), 3, "imem_stall3");
    xfer(1, 0, 32'h4, 32'h0, 4'hF, 0, ref_rd(32'h4), 1, "imem_rotated");
    do_reset(32'h0, 32'h0);
  endtask

  task automatic test_mmio();
    xfer(0, 1, 32'hF000_0100, 32'h1, 4'hF, 0, 32'h0, 1, "ext_set");
    xfer(0, 1, 32'hF000_0200, 32'h1, 4'hF, 0, 32'h0, 1, "soft_set");
    n_cmp++;
    if ({ext_irq, soft_irq} !== 2'b11) begin
      n_err++; $display("FAIL irq_high: got %b required 11", {ext_irq, soft_irq});
    end
    xfer(0, 0, 32'hF000_0100, 32'h0, 4'hF, 0, 32'h1, 1, "ext_rd1");
    xfer(0, 0, 32'hF000_0200, 32'h0, 4'hF, 0, 32'h1, 1, "soft_rd1");
    xfer(0, 1, 32'hF000_0100, 32'h0, 4'hF, 0, 32'h0, 1, "ext_clr");
    n_cmp++;
    if ({ext_irq, soft_irq} !== 2'b01) begin
      n_err++; $display("FAIL irq_ext_clr: got %b required 01", {ext_irq, soft_irq});
    end
    xfer(0, 0, 32'hF000_0100, 32'h0, 4'hF, 0, 32'h0, 1, "ext_rd0");
    xfer(0, 1, 32'hF000_0200, 32'h0, 4'hF, 0, 32'h0, 1, "soft_clr");
    xfer(0, 0, 32'hF000_0200, 32'h0, 4'hF, 0, 32'h0, 1, "soft_rd0");
    xfer(0, 1, 32'hF000_0000, 32'h41, 4'hF, 0, 32'h0, 1, "print_a");
    xfer(0, 1, 32'hF000_0000, 32'h0A, 4'hF, 0, 32'h0, 1, "print_nl");
    xfer(0, 0, 32'hF000_0000, 32'h0, 4'hF, 0, 32'h0, 1, "print_rd");
  endtask

  task automatic test_err();
    xfer(0, 0, 32'h8000_0000, 32'h0, 4'hF, 1, 32'h0, 1, "dmem_unmapped");
    xfer(1, 0, 32'hF000_0000, 32'h0, 4'hF, 1, 32'h0, 1, "imem_mmio_rd");
    xfer(1, 1, 32'hF000_0100, 32'h1, 4'hF, 1, 32'h0, 1, "imem_mmio_wr");
    n_cmp++;
    if (ext_irq !== 1'b0) begin
      n_err++; $display("FAIL imem_mmio_noeffect: ext_irq=%b required 0", ext_irq);
    end
    xfer(0, 1, 32'hF000_0300, 32'h1, 4'hF, 1, 32'h0, 1, "dmem_mmio_hole");
  endtask

  task automatic test_back_to_back();
    logic [31:0] old100;
    old100 = ref_rd(32'h100);
    ref_wr(32'h100, 32'h5566_7788, 4'hF);
    fork
      xfer(1, 0, 32'h100, 32'h0, 4'hF, 0, old100, 1, "same_edge_rd_old");
      xfer(0, 1, 32'h100, 32'h5566_7788, 4'hF, 0, 32'h0, 1, "same_edge_wr");
    join
    xfer(1, 0, 32'h100, 32'h0, 4'hF, 0, ref_rd(32'h100), 1, "same_edge_rd_new");
    fork
      xfer(1, 1, 32'h104, 32'h1111_1111, 4'hF, 0, 32'h0, 1, "collide_imem");
      xfer(0, 1, 32'h104, 32'h2222_2222, 4'b0011, 0, 32'h0, 1, "collide_dmem");
    join
    xfer(0, 0, 32'h104, 32'h0, 4'hF, 0, 32'h1111_2222, 1, "collide_result");
  endtask

  task automatic test_reset_mid();
    do_reset(32'h0, 32'hFFFF_FFFC);
    xfer(0, 1, 32'hF000_0100, 32'h1, 4'hF, 0, 32'h0, 1, "mid_ext_set");
    xfer(0, 1, 32'hF000_0200, 32'h1, 4'hF, 0, 32'h0, 1, "mid_soft_set");
    @(negedge clk);
    wbd_dmem_adr_i = 32'h100; wbd_dmem_we_i = 1'b0; wbd_dmem_sel_i = 4'hF;
    wbd_dmem_stb_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if ({wbd_dmem_ack_o, wbd_dmem_err_o, ext_irq, soft_irq} !== 4'b0011) begin
      n_err++;
      $display("FAIL mid_stalled: ack,err,ext,soft=%b required 0011",
               {wbd_dmem_ack_o, wbd_dmem_err_o, ext_irq, soft_irq});
    end
    #1;
    dmem_req_ack_stall_in = 32'h0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({wbd_dmem_ack_o, wbd_dmem_err_o, ext_irq, soft_irq} !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_async_clear: ack,err,ext,soft=%b required 0000",
               {wbd_dmem_ack_o, wbd_dmem_err_o, ext_irq, soft_irq});
    end
    wbd_dmem_stb_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    xfer(0, 0, 32'h100, 32'h0, 4'hF, 0, ref_rd(32'h100), 1, "mid_reissue");
    // reset landing while ack is high drops it without waiting for an edge
    @(negedge clk);
    wbd_dmem_adr_i = 32'h100; wbd_dmem_stb_i = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (wbd_dmem_ack_o !== 1'b1) begin
      n_err++; $display("FAIL ack_before_rst: got %b required 1", wbd_dmem_ack_o);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({wbd_dmem_ack_o, wbd_dmem_dat_o} !== 33'h0) begin
      n_err++;
      $display("FAIL ack_async_clear: ack=%b dat=%h required 0/0",
               wbd_dmem_ack_o, wbd_dmem_dat_o);
    end
    wbd_dmem_stb_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ack_stall_in = 32'h0;
    dmem_req_ack_stall_in = 32'h0;
    wbd_imem_stb_i = 1'b0; wbd_imem_adr_i = '0; wbd_imem_we_i = 1'b0;
    wbd_imem_dat_i = '0;   wbd_imem_sel_i = '0;
    wbd_dmem_stb_i = 1'b0; wbd_dmem_adr_i = '0; wbd_dmem_we_i = 1'b0;
    wbd_dmem_dat_i = '0;   wbd_dmem_sel_i = '0;
    for (int i = 0; i < 1024; i++) begin
      dut.memory[i] = 8'(i * 13 + 5);
      ref_mem[32'(i)] = 8'(i * 13 + 5);
    end
    test_reset();
    test_rw();
    test_imem_stall();
    test_mmio();
    test_err();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
